// File: rtl/frame_ddr_writer_pkg.sv
// Shared constants for the frame-to-DDR write path:
// MIG app command codes, writer FSM encoding, point packing.
package frame_ddr_writer_pkg;

    localparam logic [2:0] APP_CMD_WRITE = 3'b000;
    localparam logic [2:0] APP_CMD_READ  = 3'b001;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Point packing shared with the camera and preprocessor blocks:
    // point k sits at bits [(k+1)*W-1 : k*W] of a word.
    localparam int PT_N_POINTS    = 4;
    localparam int PT_POINT_WIDTH = 8;
    localparam int PT_WORD_WIDTH  = PT_N_POINTS * PT_POINT_WIDTH;

    function automatic int point_lsb(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, show-ahead read (rd_data is the head).
// Ports: push/wr_data in, pop/rd_data out, full/empty/count status.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/frame_ddr_writer.sv
// Buffers packed point words and writes them to DDR through the
// MIG app interface, ping-ponging frames between two banks.
// Ports: in_* stream in, app_* MIG write out, frame_* per-frame
// completion report, overrun sticky error, busy status.
import frame_ddr_writer_pkg::*;

module frame_ddr_writer #(
    parameter int N_POINTS    = PT_N_POINTS,
    parameter int POINT_WIDTH = PT_POINT_WIDTH,
    parameter int DATA_WIDTH  = N_POINTS * POINT_WIDTH,
    parameter int ADDR_WIDTH  = 28,
    parameter int FIFO_DEPTH  = 8,
    parameter int BASE_ADDR   = 0,
    parameter int BANK_STRIDE = 1 << 20,
    parameter int ADDR_STEP   = 8,
    parameter int FRAME_WORDS = 1 << 17,
    localparam int FWW = $clog2(FRAME_WORDS) + 1,
    localparam int CW  = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    init_calib_complete,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    input  logic                    in_frame_end,
    output logic                    in_ready,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    output logic                    frame_done,
    output logic                    frame_bank,
    output logic [FWW-1:0]          frame_words,
    output logic                    overrun,
    output logic                    busy
);

    localparam logic [ADDR_WIDTH-1:0] BASE0 =
        ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] BASE1 =
        ADDR_WIDTH'(BASE_ADDR + BANK_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] STEP =
        ADDR_WIDTH'(ADDR_STEP);

    logic [1:0]            state;
    logic                  bank;
    logic                  cur_end;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [FWW-1:0]        word_cnt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_end;

    logic                  push;
    logic                  pop;
    logic                  can_issue;
    logic                  start;
    logic                  word_ok;
    logic                  last;
    logic [FWW-1:0]        cnt_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    assign push      = in_valid && !fifo_full;
    assign can_issue = init_calib_complete && !fifo_empty;
    assign start     = (state == ST_IDLE) && can_issue;

    // Word retires once each half of the handshake has been
    // taken, whether in separate cycles or together.
    assign word_ok   = (state == ST_ISSUE)
                    && (!app_en || app_rdy)
                    && (!app_wdf_wren || app_wdf_rdy);
    assign cnt_next  = word_cnt + 1'b1;
    assign last      = cur_end
                    || (cnt_next == FWW'(FRAME_WORDS));
    assign addr_next = cur_addr + STEP;
    assign pop       = start
                    || (word_ok && !last && can_issue);

    sync_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({in_frame_end, in_data}),
        .pop     (pop),
        .rd_data ({head_end, head_data}),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bank         <= 1'b0;
            cur_end      <= 1'b0;
            cur_addr     <= BASE0;
            word_cnt     <= '0;
            app_en       <= 1'b0;
            app_wdf_wren <= 1'b0;
            app_addr     <= BASE0;
            app_wdf_data <= '0;
            frame_done   <= 1'b0;
            frame_bank   <= 1'b0;
            frame_words  <= '0;
            overrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        app_en       <= 1'b1;
                        app_wdf_wren <= 1'b1;
                        app_addr     <= cur_addr;
                        app_wdf_data <= head_data;
                        cur_end      <= head_end;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (app_en && app_rdy)
                        app_en <= 1'b0;
                    if (app_wdf_wren && app_wdf_rdy)
                        app_wdf_wren <= 1'b0;
                    if (word_ok) begin
                        word_cnt <= cnt_next;
                        if (last) begin
                            state       <= ST_DONE;
                            frame_done  <= 1'b1;
                            frame_bank  <= bank;
                            frame_words <= cnt_next;
                            if (!cur_end) overrun <= 1'b1;
                        end else begin
                            cur_addr <= addr_next;
                            if (can_issue) begin
                                app_en       <= 1'b1;
                                app_wdf_wren <= 1'b1;
                                app_addr     <= addr_next;
                                app_wdf_data <= head_data;
                                cur_end      <= head_end;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    bank     <= ~bank;
                    cur_addr <= bank ? BASE0 : BASE1;
                    word_cnt <= '0;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready     = !fifo_full;
    assign app_cmd      = APP_CMD_WRITE;
    assign app_wdf_mask = '0;
    assign app_wdf_end  = app_wdf_wren;
    assign busy         = (fifo_count != '0)
                       || (state != ST_IDLE);

endmodule

// File: tb/tb_frame_ddr_writer.sv
// Self-checking bench for frame_ddr_writer: directed scenarios plus
// randomized traffic against a frame/bank address model.
module tb_frame_ddr_writer;

    localparam int DW     = 32;
    localparam int AW     = 28;
    localparam int DEPTH  = 8;
    localparam int STRIDE = 1 << 20;
    localparam int STEP   = 8;
    localparam int FW     = 4;
    localparam int FWW    = $clog2(FW) + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct packed {
        logic           bank;
        logic [FWW-1:0] words;
        logic           ovr;
    } fr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              init_calib_complete = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_frame_end = 1'b0;
    logic              in_ready;
    logic [AW-1:0]     app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy = 1'b0;
    logic [DW-1:0]     app_wdf_data;
    logic [DW/8-1:0]   app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy = 1'b0;
    logic              frame_done;
    logic              frame_bank;
    logic [FWW-1:0]    frame_words;
    logic              overrun;
    logic              busy;

    frame_ddr_writer #(
        .ADDR_WIDTH  (AW),
        .FIFO_DEPTH  (DEPTH),
        .BASE_ADDR   (0),
        .BANK_STRIDE (STRIDE),
        .ADDR_STEP   (STEP),
        .FRAME_WORDS (FW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .in_data             (in_data),
        .in_valid            (in_valid),
        .in_frame_end        (in_frame_end),
        .in_ready            (in_ready),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .frame_done          (frame_done),
        .frame_bank          (frame_bank),
        .frame_words         (frame_words),
        .overrun             (overrun),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Sink readiness / calibration drivers
    int   rand_mode = 0;
    logic man_rdy   = 1'b1;
    logic man_wrdy  = 1'b1;
    logic man_calib = 1'b1;

    always @(posedge clk) begin
        #2;
        if (rand_mode != 0) begin
            app_rdy             = ($urandom_range(0, 3) != 0);
            app_wdf_rdy         = ($urandom_range(0, 3) != 0);
            init_calib_complete = ($urandom_range(0, 9) != 0);
        end else begin
            app_rdy             = man_rdy;
            app_wdf_rdy         = man_wrdy;
            init_calib_complete = man_calib;
        end
    end

    // Reference model: each accepted word lands at
    // base + bank*stride + index*step; a frame closes on its
    // flagged word or on the FW-th word (then flagged overrun).
    wr_t           exp_wr[$];
    fr_t           exp_fr[$];
    logic [AW-1:0] got_addr[$];
    logic [DW-1:0] got_data[$];
    logic [AW-1:0] wlog[$];
    fr_t           flog[$];
    int            m_bank;
    int            m_idx;
    logic          m_ovr;

    function automatic void model_push(input logic [DW-1:0] d,
                                       input logic e);
        wr_t w;
        fr_t f;
        w.addr = AW'(m_bank * STRIDE + m_idx * STEP);
        w.data = d;
        exp_wr.push_back(w);
        m_idx++;
        if (e || m_idx == FW) begin
            if (!e) m_ovr = 1'b1;
            f.bank  = m_bank[0];
            f.words = FWW'(m_idx);
            f.ovr   = m_ovr;
            exp_fr.push_back(f);
            m_bank ^= 1;
            m_idx = 0;
        end
    endfunction

    logic          p_en, p_wr, p_rdy, p_wrdy, p_done, p_calib;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_data;
    wr_t           g, e;
    fr_t           gf, ef;

    always @(negedge clk) begin
        if (rst) begin
            exp_wr.delete();
            exp_fr.delete();
            got_addr.delete();
            got_data.delete();
            wlog.delete();
            flog.delete();
            m_bank = 0;
            m_idx = 0;
            m_ovr = 1'b0;
            {p_en, p_wr, p_rdy, p_wrdy, p_done, p_calib} = '0;
            p_addr = '0;
            p_data = '0;
        end else begin
            if (in_valid && in_ready)
                model_push(in_data, in_frame_end);
            if (p_en && !p_rdy) begin
                check("en_hold", app_en, 1);
                check("addr_hold", app_addr, p_addr);
            end
            if (p_wr && !p_wrdy) begin
                check("wren_hold", app_wdf_wren, 1);
                check("data_hold", app_wdf_data, p_data);
            end
            if (app_en && !p_en)
                check("issue_needs_calib", p_calib, 1);
            if (app_en && app_rdy)
                got_addr.push_back(app_addr);
            if (app_wdf_wren && app_wdf_rdy)
                got_data.push_back(app_wdf_data);
            while (got_addr.size() > 0 && got_data.size() > 0) begin
                g.addr = got_addr.pop_front();
                g.data = got_data.pop_front();
                wlog.push_back(g.addr);
                if (exp_wr.size() == 0) begin
                    check("extra_write", 1, 0);
                end else begin
                    e = exp_wr.pop_front();
                    check("wr_addr", g.addr, e.addr);
                    check("wr_data", g.data, e.data);
                end
            end
            if (frame_done) begin
                check("done_one_cycle", p_done, 0);
                gf.bank  = frame_bank;
                gf.words = frame_words;
                gf.ovr   = overrun;
                flog.push_back(gf);
                if (exp_fr.size() == 0) begin
                    check("extra_done", 1, 0);
                end else begin
                    ef = exp_fr.pop_front();
                    check("fr_bank", gf.bank, ef.bank);
                    check("fr_words", gf.words, ef.words);
                    check("fr_overrun", gf.ovr, ef.ovr);
                end
            end
            p_en    = app_en;
            p_wr    = app_wdf_wren;
            p_rdy   = app_rdy;
            p_wrdy  = app_wdf_rdy;
            p_done  = frame_done;
            p_calib = init_calib_complete;
            p_addr  = app_addr;
            p_data  = app_wdf_data;
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic fe);
        int t = 0;
        in_data      = d;
        in_frame_end = fe;
        in_valid     = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 2000) begin
            t++;
            @(negedge clk);
        end
        if (t >= 2000) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        rand_mode = 0;
        man_rdy   = 1'b1;
        man_wrdy  = 1'b1;
        man_calib = 1'b1;
        while ((busy || exp_wr.size() != 0) && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", (t < 1000), 1);
        repeat (3) @(posedge clk);
        #1;
        check("wr_pending", exp_wr.size(), 0);
        check("fr_pending", exp_fr.size(), 0);
        check("half_pending", got_addr.size() + got_data.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_app_en", app_en, 0);
        check("rst_wren", app_wdf_wren, 0);
        check("rst_addr", app_addr, 0);
        check("rst_wdata", app_wdf_data, 0);
        check("rst_done", frame_done, 0);
        check("rst_fbank", frame_bank, 0);
        check("rst_fwords", frame_words, 0);
        check("rst_overrun", overrun, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("app_cmd", app_cmd, 0);
        check("wdf_mask", app_wdf_mask, 0);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_en();
        int t = 0;
        while (!app_en && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("app_en_timeout", app_en, 1);
    endtask

    task automatic chk_addr(input string tag, input int i,
                            input int exp);
        if (wlog.size() > i) check(tag, wlog[i], AW'(exp));
        else check({tag, "_missing"}, wlog.size(), i + 1);
    endtask

    task automatic chk_frame(input string tag, input int i,
                             input int bk, input int words,
                             input int ovr);
        if (flog.size() > i) begin
            check({tag, "_bank"}, flog[i].bank, bk);
            check({tag, "_words"}, flog[i].words, words);
            check({tag, "_ovr"}, flog[i].ovr, ovr);
        end else begin
            check({tag, "_missing"}, flog.size(), i + 1);
        end
    endtask

    int k;
    int n;
    logic low_seen;

    initial begin
        do_reset();

        // single 3-word frame
        send(32'h01020304, 1'b0);
        send(32'h05060708, 1'b0);
        send(32'h090A0B0C, 1'b1);
        drain();
        chk_addr("s_a0", 0, 0);
        chk_addr("s_a1", 1, 8);
        chk_addr("s_a2", 2, 16);
        chk_frame("s_fr", 0, 0, 3, 0);

        // bank toggle and return
        do_reset();
        for (int i = 0; i < 5; i++)
            send(32'hB000_0000 + i, (i == 1 || i == 3 || i == 4));
        drain();
        chk_addr("bt_a1", 1, 8);
        chk_addr("bt_a2", 2, STRIDE);
        chk_addr("bt_a3", 3, STRIDE + 8);
        chk_addr("bt_a4", 4, 0);
        chk_frame("bt_f0", 0, 0, 2, 0);
        chk_frame("bt_f1", 1, 1, 2, 0);
        chk_frame("bt_f2", 2, 0, 1, 0);

        // split handshake on a single-word frame
        do_reset();
        man_rdy  = 1'b0;
        man_wrdy = 1'b0;
        send(32'hC0DE_0001, 1'b1);
        wait_en();
        @(posedge clk);
        #1;
        man_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("split_en_low", app_en, 0);
        check("split_wren_hi", app_wdf_wren, 1);
        repeat (2) @(posedge clk);
        #1;
        check("split_wren_hold", app_wdf_wren, 1);
        check("split_data", app_wdf_data, 32'hC0DE_0001);
        man_wrdy = 1'b1;
        drain();
        check("split_nwrites", wlog.size(), 1);
        chk_frame("split_fr", 0, 0, 1, 0);

        // backpressure with continuous stream
        do_reset();
        man_rdy  = 1'b0;
        man_wrdy = 1'b1;
        k = 0;
        low_seen = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data      = 32'hA000_0000 + k;
            in_frame_end = (k % 4 == 3);
            @(negedge clk);
            if (in_ready) begin
                k++;
            end else if (!low_seen) begin
                low_seen = 1'b1;
                check("bp_accepted", k, DEPTH + 1);
            end
            @(posedge clk);
            #1;
        end
        check("bp_ready_low", low_seen, 1);
        man_rdy = 1'b1;
        while (k < 16) begin
            send(32'hA000_0000 + k, (k % 4 == 3));
            k++;
        end
        drain();
        check("bp_nwrites", wlog.size(), 16);
        check("bp_nframes", flog.size(), 4);

        // overrun: 6 words without a frame end
        do_reset();
        for (int i = 0; i < 6; i++)
            send(32'hD000_0000 + i, 1'b0);
        drain();
        chk_addr("ov_a3", 3, 24);
        chk_addr("ov_a4", 4, STRIDE);
        chk_addr("ov_a5", 5, STRIDE + 8);
        chk_frame("ov_fr", 0, 1'b0, 4, 1);
        check("ov_sticky", overrun, 1);
        check("ov_nframes", flog.size(), 1);

        // randomized traffic with calibration drops
        do_reset();
        rand_mode = 1;
        for (int f = 0; f < 30; f++) begin
            n = $urandom_range(1, 5);
            for (int w = 0; w < n; w++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
                send($urandom, (w == n - 1));
            end
        end
        drain();

        // reset during an in-flight word with 3 queued
        do_reset();
        man_rdy  = 1'b0;
        man_wrdy = 1'b0;
        for (int i = 0; i < 4; i++)
            send(32'hE000_0000 + i, 1'b0);
        wait_en();
        do_reset();
        man_rdy  = 1'b1;
        man_wrdy = 1'b1;
        send(32'hF000_0000, 1'b0);
        send(32'hF000_0001, 1'b1);
        drain();
        check("rr_nwrites", wlog.size(), 2);
        chk_addr("rr_a0", 0, 0);
        chk_addr("rr_a1", 1, 8);
        chk_frame("rr_fr", 0, 0, 2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/frame_ddr_writer.md
FRAME_DDR_WRITER -- requirements
Module: frame_ddr_writer

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- N_POINTS, 4, preprocessed points per input word
- POINT_WIDTH, 8, bits per preprocessed point
- DATA_WIDTH, N_POINTS*POINT_WIDTH, input and app write-data width
- ADDR_WIDTH, 28, app_addr width
- FIFO_DEPTH, 8, input FIFO entries, power of 2, >=2
- BASE_ADDR, 0, address of bank 0
- BANK_STRIDE, 2^20, address offset of bank 1 from bank 0
- ADDR_STEP, 8, address increment per word written
- FRAME_WORDS, 2^17, maximum words per frame
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, in, 1, single clock (DDR user-interface clock)
- rst, in, 1, asynchronous active-high reset
- init_calib_complete, in, 1, DDR ready
- in_data, in, DATA_WIDTH, packed points, point k at bits [(k+1)*POINT_WIDTH-1 : k*POINT_WIDTH]
- in_valid, in, 1, in_data valid
- in_frame_end, in, 1, word is last of frame
- in_ready, out, 1, FIFO can accept
- app_addr, out, ADDR_WIDTH, write address
- app_cmd, out, 3, fixed 3'b000
- app_en, out, 1, command valid
- app_rdy, in, 1, command accepted
- app_wdf_data, out, DATA_WIDTH, write data
- app_wdf_mask, out, DATA_WIDTH/8, fixed 0
- app_wdf_wren, out, 1, data valid
- app_wdf_end, out, 1, equals app_wdf_wren
- app_wdf_rdy, in, 1, data accepted
- frame_done, out, 1, one-cycle pulse when a frame's last word is accepted
- frame_bank, out, 1, bank of completed frame, valid with frame_done
- frame_words, out, clog2(FRAME_WORDS)+1, words in completed frame, valid with frame_done
- overrun, out, 1, sticky: a frame exceeded FRAME_WORDS
- busy, out, 1, FIFO non-empty or write in flight

Function
REQ-003 Input transfer occurs when in_valid && in_ready; {in_frame_end, in_data} is pushed into the FIFO.
REQ-004 in_ready SHALL equal !full; push and pop in the same cycle are permitted whenever not full; push while full never occurs.
REQ-005 FSM states: IDLE, ISSUE, DONE.
REQ-006 IDLE -> ISSUE when init_calib_complete && FIFO non-empty; the head is popped and app_en, app_wdf_wren, app_addr and app_wdf_data are registered in the same edge.
REQ-007 In ISSUE, app_en SHALL clear on the edge where app_en && app_rdy, and app_wdf_wren on the edge where app_wdf_wren && app_wdf_rdy, independently; outputs stay stable until accepted.
REQ-008 The word is complete when both have been accepted, including both in the same cycle. If the word was not a frame end: address += ADDR_STEP. Then, if the FIFO is non-empty and calibration is complete, the next word issues on that same edge (back-to-back, one word/cycle peak); otherwise -> IDLE.
REQ-009 On completion of a frame-end word -> DONE. DONE lasts one cycle and asserts frame_done, frame_bank and frame_words. The bank toggles, the address resets to the new bank base, the word counter clears, and the state goes to IDLE.
REQ-010 Address = BASE_ADDR + bank*BANK_STRIDE + word_index*ADDR_STEP, truncated to ADDR_WIDTH.
REQ-011 Boundary: if FRAME_WORDS words complete without a frame end, set overrun and treat the FRAME_WORDS-th word as a frame end (DONE, bank toggle). Later input continues as a new frame.
REQ-012 Boundary: a single-word frame (frame end on the first word) SHALL give frame_words=1.
REQ-013 Boundary: init_calib_complete deasserting does not abort an in-flight word; new issues are held.

Reset
REQ-014 Asynchronous rst SHALL force: state IDLE, FIFO empty, app_en=0, app_wdf_wren=0, app_addr=BASE_ADDR, app_wdf_data=0, frame_done=0, frame_bank=0, frame_words=0, overrun=0, bank=0.
REQ-015 Reset mid-write discards the FIFO contents and the in-flight word; the first frame after reset starts in bank 0 at BASE_ADDR.

Structure
REQ-016 A shared package SHALL hold: the app command encodings (WRITE=3'b000, READ=3'b001), the FSM state encoding, and the point-width/packing constants used by the camera and preprocessor blocks.
REQ-017 One sub-module, sync_fifo (parametrised width/depth, full/empty/count), SHALL implement the input buffer.

Verification
REQ-018 Single frame: 3 words 0x01020304, 0x05060708, 0x090A0B0C (last flagged), app_rdy=app_wdf_rdy=1 -> addresses 0, 8, 16; frame_done pulse with bank 0, frame_words 3.
REQ-019 Bank toggle: two 2-word frames -> second frame at BANK_STRIDE, BANK_STRIDE+8; frame_bank 0 then 1; third frame returns to address 0.
REQ-020 Split handshake: app_rdy high 3 cycles before app_wdf_rdy -> app_en drops first, app_wdf_wren holds data stable until accepted; exactly one write per word.
REQ-021 Backpressure: app_rdy=0 for 20 cycles with a continuous input stream -> in_ready low after FIFO_DEPTH+1 words; no word lost or duplicated after release.
REQ-022 Overrun: FRAME_WORDS=4, 6 words without frame end -> frame_done after word 4, overrun=1, words 5-6 to bank 1 addresses BANK_STRIDE, +8.
REQ-023 Reset during ISSUE with 3 words queued -> app_en/app_wdf_wren drop immediately; next frame starts at BASE_ADDR, bank 0.
